// File: rtl/execute_stage_if.sv
// Handshake and data bundle between the decode stage, execute_stage and write-back.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready
// are both 1; the sender holds its payload stable while valid=1 and ready=0.
interface execute_stage_if #(
  parameter int data_width    = 16,
  parameter int address_width = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_op;
  logic [data_width-1:0]    in_a;
  logic [data_width-1:0]    in_b;
  logic [data_width-1:0]    in_imm;
  logic                     in_use_imm;
  logic [address_width-1:0] in_dest;
  logic                     in_wb;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [data_width-1:0]    out_result;
  logic [address_width-1:0] out_dest;
  logic                     out_wb;
  logic [2:0]               flags;
  logic                     busy;
  logic                     dbg_state;

  modport master (
    output in_valid, in_op, in_a, in_b, in_imm, in_use_imm, in_dest, in_wb, flush, out_ready,
    input  in_ready, out_valid, out_result, out_dest, out_wb, flags, busy, dbg_state
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_imm, in_use_imm, in_dest, in_wb, flush, out_ready,
    output in_ready, out_valid, out_result, out_dest, out_wb, flags, busy, dbg_state
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier, with a
// registered result/flags interface and a flush that kills in-flight and pending work.
module execute_stage #(
  parameter int data_width    = 16,
  parameter int address_width = 3
) (
  input logic              clk,
  input logic              rst_n,
  execute_stage_if.slave   bus
);

  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_INC  = 4'd7;
  localparam logic [3:0] OP_DEC  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_SETC = 4'd12;
  localparam logic [3:0] OP_CLRC = 4'd13;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t                   state, state_next;
  logic [4:0]               cnt;
  logic [data_width-1:0]    mul_acc, mul_mcand, mul_mplier, mul_sum;
  logic [address_width-1:0] mul_dest;
  logic                     mul_wb;
  logic                     mul_done;

  logic                     out_valid_q;
  logic [data_width-1:0]    out_result_q;
  logic [address_width-1:0] out_dest_q;
  logic                     out_wb_q;
  logic                     flag_c, flag_n, flag_z;

  logic                     accept;
  logic [data_width-1:0]    op_b;
  logic [3:0]               shamt;
  logic [data_width-1:0]    alu_result;
  logic                     alu_c, alu_c_upd, alu_zn_upd, alu_wb_ok;

  assign op_b     = bus.in_use_imm ? bus.in_imm : bus.in_b;
  assign shamt    = op_b[3:0];
  assign accept   = bus.in_valid && bus.in_ready && !bus.flush;
  // One multiplier bit is consumed per edge; the last bit lands on the 16th edge.
  assign mul_sum  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_done = (state == S_MUL) && (cnt == 5'(data_width - 1));

  assign bus.in_ready   = rst_n && (state == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_dest   = out_dest_q;
  assign bus.out_wb     = out_wb_q;
  assign bus.flags      = {flag_c, flag_n, flag_z};
  assign bus.busy       = (state == S_MUL);
  assign bus.dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && bus.in_op == OP_MUL) state_next = S_MUL;
      S_MUL:   if (mul_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (bus.flush) state_next = S_IDLE;
  end

  // Single-cycle ALU; carry is produced by widening the operands by one bit.
  always_comb begin
    alu_result = '0;
    alu_c      = flag_c;
    alu_c_upd  = 1'b0;
    alu_zn_upd = 1'b1;
    alu_wb_ok  = 1'b1;
    case (bus.in_op)
      OP_MOV: alu_result = op_b;
      OP_ADD: begin
        {alu_c, alu_result} = {1'b0, bus.in_a} + {1'b0, op_b};
        alu_c_upd = 1'b1;
      end
      OP_SUB: begin
        alu_result = bus.in_a - op_b;
        alu_c      = (bus.in_a < op_b);
        alu_c_upd  = 1'b1;
      end
      OP_AND: alu_result = bus.in_a & op_b;
      OP_OR:  alu_result = bus.in_a | op_b;
      OP_NOT: alu_result = ~bus.in_a;
      OP_INC: begin
        {alu_c, alu_result} = {1'b0, bus.in_a} + (data_width + 1)'(1);
        alu_c_upd = 1'b1;
      end
      OP_DEC: begin
        alu_result = bus.in_a - data_width'(1);
        alu_c      = (bus.in_a == '0);
        alu_c_upd  = 1'b1;
      end
      OP_SHL: begin
        {alu_c, alu_result} = {1'b0, bus.in_a} << shamt;
        alu_c_upd = (shamt != 4'd0);
      end
      OP_SHR: begin
        {alu_result, alu_c} = {bus.in_a, 1'b0} >> shamt;
        alu_c_upd = (shamt != 4'd0);
      end
      OP_SETC: begin
        alu_c     = 1'b1;
        alu_c_upd = 1'b1;
        alu_wb_ok = 1'b0;
      end
      OP_CLRC: begin
        alu_c     = 1'b0;
        alu_c_upd = 1'b1;
        alu_wb_ok = 1'b0;
      end
      default: begin
        alu_zn_upd = 1'b0;
        alu_wb_ok  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      mul_acc      <= '0;
      mul_mcand    <= '0;
      mul_mplier   <= '0;
      mul_dest     <= '0;
      mul_wb       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_dest_q   <= '0;
      out_wb_q     <= 1'b0;
      flag_c       <= 1'b0;
      flag_n       <= 1'b0;
      flag_z       <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      cnt         <= '0;
    end else begin
      if (bus.out_ready) out_valid_q <= 1'b0;
      if (state == S_MUL) begin
        mul_acc    <= mul_sum;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        cnt        <= cnt + 5'd1;
        if (mul_done) begin
          cnt          <= '0;
          out_valid_q  <= 1'b1;
          out_result_q <= mul_sum;
          out_dest_q   <= mul_dest;
          out_wb_q     <= mul_wb;
          flag_z       <= (mul_sum == '0);
          flag_n       <= mul_sum[data_width-1];
        end
      end else if (accept) begin
        if (bus.in_op == OP_MUL) begin
          cnt        <= '0;
          mul_acc    <= '0;
          mul_mcand  <= bus.in_a;
          mul_mplier <= op_b;
          mul_dest   <= bus.in_dest;
          mul_wb     <= bus.in_wb;
        end else begin
          out_valid_q  <= 1'b1;
          out_result_q <= alu_result;
          out_dest_q   <= bus.in_dest;
          out_wb_q     <= bus.in_wb && alu_wb_ok;
          if (alu_zn_upd) begin
            flag_z <= (alu_result == '0);
            flag_n <= alu_result[data_width-1];
          end
          if (alu_c_upd) flag_c <= alu_c;
        end
      end
    end
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter: data_width, 16, operand/result width.
REQ-002 SHALL have parameter: address_width, 3, register-file destination address width.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept.
- in_op  input  4  opcode.
- in_a  input  data_width  read_data1 from register file.
- in_b  input  data_width  read_data2 from register file.
- in_imm  input  data_width  immediate.
- in_use_imm  input  1  replace in_b with in_imm.
- in_dest  input  address_width  destination register.
- in_wb  input  1  write-back requested.
- flush  input  1  kill in-flight and pending work.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts.
- out_result  output  data_width  result.
- out_dest  output  address_width  destination register.
- out_wb  output  1  write-back enable.
- flags  output  3  {C,N,Z} condition register.
- busy  output  1  multiply in progress.

Function
REQ-004 SHALL accept an instruction on a rising edge where in_valid and in_ready are both 1; B denotes in_imm when in_use_imm=1, else in_b.
REQ-005 SHALL drive in_ready = (state==IDLE) and (out_valid==0 or out_ready==1).
REQ-006 SHALL decode opcodes as: 0 NOP; 1 MOV (B); 2 ADD (a+B); 3 SUB (a-B); 4 AND; 5 OR; 6 NOT a; 7 INC a; 8 DEC a; 9 SHL a by B[3:0]; 10 SHR (logical) a by B[3:0]; 11 MUL (low data_width bits of a*B); 12 SETC; 13 CLRC; 14-15 treated as NOP.
REQ-007 SHALL, for every non-MUL op, register out_result/out_dest/out_wb and set out_valid at the acceptance edge (1-cycle latency).
REQ-008 SHALL force out_wb=0 for NOP, SETC, CLRC and for undefined opcodes, and pass in_wb otherwise.
REQ-009 SHALL implement a two-state FSM: IDLE, MUL; accepting op 11 moves IDLE->MUL and loads a 5-bit counter with 0.
REQ-010 SHALL perform MUL as iterative shift-add, one bit per cycle, with the counter incrementing each edge in MUL.
REQ-011 SHALL, on the 16th edge after acceptance, register the product, set out_valid, and return to IDLE; busy=1 exactly while in MUL.
REQ-012 SHALL hold out_result/out_dest/out_wb stable while out_valid=1 and out_ready=0, and clear out_valid on an edge where out_ready=1 unless a new result is loaded on that same edge.
REQ-013 SHALL update flags at the edge the result is registered: Z = (result==0), N = result MSB.
REQ-014 SHALL set C as: carry-out for ADD/INC; borrow for SUB/DEC (a<B, or a==0 for DEC); last bit shifted out for SHL/SHR, with C unchanged for a shift amount of 0; C=1 for SETC; C=0 for CLRC.
REQ-015 SHALL leave C unchanged for MOV/AND/OR/NOT/MUL, and leave all flags unchanged for NOP and undefined opcodes.
REQ-016 SHALL, when flush=1 at an edge: clear out_valid, abort MUL (return to IDLE, busy=0), and perform no acceptance or flag update on that edge; flush has priority over every other event.
REQ-017 SHALL wrap arithmetic modulo 2^data_width (0xFFFF+1=0x0000 with C=1; 0x0000-1=0xFFFF with C=1).

Reset
REQ-018 SHALL, while rst_n=0 (asynchronously), force state=IDLE, counter=0, out_valid=0, out_result=0, out_dest=0, out_wb=0, flags=000, busy=0; this aborts any MUL in progress.
REQ-019 SHALL drive in_ready=1 in the first cycle after rst_n is released.

Verification
REQ-020 SHALL cover: ADD a=0xFFFF, B=0x0001, out_ready=1 -> next cycle out_result=0x0000, out_valid=1, flags Z=1, N=0, C=1.
REQ-021 SHALL cover: MUL a=0x0012, B=0x0034 -> busy=1 and in_ready=0 for 16 cycles; then out_result=0x03A8, out_valid=1; C unchanged.
REQ-022 SHALL cover: out_ready=0 for 3 cycles after SUB 5-7 -> out_result holds 0xFFFE, N=1, C=1, in_ready=0; result clears after out_ready=1.
REQ-023 SHALL cover: flush asserted at the 8th MUL cycle -> out_valid stays 0, busy=0 next cycle, flags unchanged, new ADD accepted next cycle.
REQ-024 SHALL cover: rst_n low mid-MUL -> all outputs 0 immediately, without waiting for a clock edge.
REQ-025 SHALL cover: SHL a=0x8001 by B=0x0001 with in_use_imm=1 (imm=1, in_b=0x000F) -> out_result=0x0002, C=1.
